// File: rtl/lz77_pkg.sv
// Shared LZ77 encoder/decoder parameters, end-of-stream sign and state type.
// Optional build macro used by the decoder: LZ77_DEC_OUTCNT_EN.
package lz77_pkg;

    localparam int Wsearch = 9;
    localparam int Wchar   = 8;
    localparam int Woff    = 4;
    localparam int Wlen    = 3;

    localparam logic [Wchar-1:0] EndSgn = 8'h24;

    typedef enum logic [1:0] {
        IDLE,
        COPY,
        LIT,
        FIN
    } state_t;

endpackage

// File: rtl/lz77_search_buf.sv
// Search buffer: Wsearch-deep character shift register, entry 0 newest.
// Reads past the last entry return zero.
module lz77_search_buf
    import lz77_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic [Wchar-1:0] din,
    input  logic [Woff-1:0]  rd_off,
    output logic [Wchar-1:0] rd_data
);

    localparam logic [Woff:0] SearchLim = (Woff+1)'(Wsearch);

    logic [Wchar-1:0] mem [Wsearch];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < Wsearch; i++) begin
                mem[i] <= '0;
            end
        end else if (shift_en) begin
            mem[0] <= din;
            for (int unsigned i = 1; i < Wsearch; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if ({1'b0, rd_off} < SearchLim) begin
            rd_data = mem[rd_off];
        end
    end

endmodule

// File: rtl/lz77_decoder.sv
// LZ77 triplet decoder: (offset, len, char) in, one character per cycle out.
// Define LZ77_DEC_OUTCNT_EN to add the out_cnt emitted-character counter port.
module lz77_decoder
    import lz77_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             code_valid,
    output logic             code_ready,
    input  logic [Woff-1:0]  code_offset,
    input  logic [Wlen-1:0]  code_len,
    input  logic [Wchar-1:0] code_char,
    output logic             char_valid,
    output logic [Wchar-1:0] char_out,
    output logic             encode,
    output logic             finish,
    output logic             proto_err
`ifdef LZ77_DEC_OUTCNT_EN
    ,
    output logic [11:0]      out_cnt
`endif
);

    localparam logic [Woff:0] SearchLim = (Woff+1)'(Wsearch);

    state_t           state;
    logic [Woff-1:0]  off_q;
    logic [Wlen-1:0]  cnt;
    logic [Wchar-1:0] char_q;

    logic             shift_en;
    logic [Wchar-1:0] din;
    logic [Wchar-1:0] rd_data;

    assign encode = 1'b0;

    lz77_search_buf u_search_buf (
        .clk      (clk),
        .reset    (reset),
        .shift_en (shift_en),
        .din      (din),
        .rd_off   (off_q),
        .rd_data  (rd_data)
    );

    // The character emitted this cycle also enters the buffer, so a fixed
    // off_q walks forward through overlapping copies on its own.
    always_comb begin
        shift_en = 1'b0;
        din      = char_q;
        case (state)
            COPY: begin
                shift_en = 1'b1;
                din      = rd_data;
            end
            LIT: begin
                shift_en = (char_q != EndSgn);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            off_q      <= '0;
            cnt        <= '0;
            char_q     <= '0;
            char_valid <= 1'b0;
            char_out   <= '0;
            finish     <= 1'b0;
            proto_err  <= 1'b0;
            code_ready <= 1'b0;
`ifdef LZ77_DEC_OUTCNT_EN
            out_cnt    <= '0;
`endif
        end else begin
            char_valid <= shift_en;
            if (shift_en) begin
                char_out <= din;
`ifdef LZ77_DEC_OUTCNT_EN
                out_cnt  <= out_cnt + 12'd1;
`endif
            end

            case (state)
                IDLE: begin
                    if (code_valid && code_ready) begin
                        off_q      <= code_offset;
                        cnt        <= code_len;
                        char_q     <= code_char;
                        code_ready <= 1'b0;
                        if ({1'b0, code_offset} >= SearchLim) begin
                            proto_err <= 1'b1;
                        end
                        state <= (code_len != '0) ? COPY : LIT;
                    end else begin
                        code_ready <= 1'b1;
                    end
                end
                COPY: begin
                    cnt <= cnt - Wlen'(1);
                    if (cnt == Wlen'(1)) begin
                        state <= LIT;
                    end
                end
                LIT: begin
                    if (char_q == EndSgn) begin
                        state  <= FIN;
                        finish <= 1'b1;
                    end else begin
                        state      <= IDLE;
                        code_ready <= 1'b1;
                    end
                end
                FIN: begin
                    finish     <= 1'b1;
                    code_ready <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
